// File: rtl/bru_pkg.sv
// Shared types and constants for the branch resolve unit.
//   BRU_XLEN    : PC width that the slot type is built for
//   PC_INC      : sequential fetch increment
//   pred_slot_t : one pipeline slot carrying a fetched instruction's prediction
//   SLOT_BUBBLE : empty (all-zero) slot
package bru_pkg;

  localparam int unsigned BRU_XLEN = 32;
  localparam int unsigned PC_INC   = 4;

  typedef struct packed {
    logic                valid;
    logic [BRU_XLEN-1:0] pc;
    logic                pred_taken;
    logic [BRU_XLEN-1:0] pred_pc;
  } pred_slot_t;

  localparam pred_slot_t SLOT_BUBBLE = '0;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Bundle of fetch-side, execute-side and predictor-training signals of the
// branch resolve unit.
//   master : pipeline side, drives IF/stall/EX inputs, observes results
//   slave  : branch_resolve_unit itself
interface branch_resolve_unit_if #(
  parameter int unsigned XLEN = 32
);

  // Fetch stage
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic            if_pred_taken;
  logic [XLEN-1:0] if_pred_pc;
  logic            stall;
  // Execute stage resolution
  logic            ex_is_ctrl;
  logic            ex_taken;
  logic [XLEN-1:0] ex_target;
  // Results
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;
  // Predictor training
  logic            bp_update;
  logic [XLEN-1:0] bp_pc;
  logic [XLEN-1:0] bp_target;
  logic            bp_taken;

  modport master (
    output if_valid, if_pc, if_pred_taken, if_pred_pc, stall,
    output ex_is_ctrl, ex_taken, ex_target,
    input  ex_valid, ex_pc, mispredict, redirect_pc,
    input  bp_update, bp_pc, bp_target, bp_taken
  );

  modport slave (
    input  if_valid, if_pc, if_pred_taken, if_pred_pc, stall,
    input  ex_is_ctrl, ex_taken, ex_target,
    output ex_valid, ex_pc, mispredict, redirect_pc,
    output bp_update, bp_pc, bp_target, bp_taken
  );

endinterface

// File: rtl/bru_compare.sv
// Combinational EX-stage resolution: computes the real next PC and flags a
// mispredict when the predicted next PC disagrees.
//   ex_valid_i, ex_pc_i, pred_pc_i : ID/EX slot contents
//   ex_is_ctrl_i, ex_taken_i, ex_target_i : actual outcome from EX
//   mispredict_o, redirect_pc_o : flush request and correct next PC (0 when idle)
module bru_compare
  import bru_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            ex_valid_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] pred_pc_i,
  input  logic            ex_is_ctrl_i,
  input  logic            ex_taken_i,
  input  logic [XLEN-1:0] ex_target_i,
  output logic            mispredict_o,
  output logic [XLEN-1:0] redirect_pc_o
);

  logic [XLEN-1:0] actual_next;

  always_comb begin
    // Non-control instructions always fall through; the add wraps modulo 2^XLEN.
    actual_next   = (ex_is_ctrl_i && ex_taken_i) ? ex_target_i : ex_pc_i + XLEN'(PC_INC);
    // Also catches predicted-taken non-control instructions (predictor aliasing).
    mispredict_o  = ex_valid_i && (pred_pc_i != actual_next);
    redirect_pc_o = mispredict_o ? actual_next : '0;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Carries each fetched instruction's prediction through IF/ID and ID/EX, resolves
// it in EX, raises flush/redirect on mismatch and emits a registered training
// pulse to the fetch-stage predictor one cycle after a control instruction leaves EX.
//   clk, reset : clock, synchronous active-high reset
//   bus        : branch_resolve_unit_if slave modport (IF, stall, EX, results, training)
//   perf_ctrl_cnt, perf_mispred_cnt : only when BRU_PERF_CNT_EN is defined
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int unsigned XLEN  = BRU_XLEN,  // must equal BRU_XLEN (slot type width)
  parameter int unsigned CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
`ifdef BRU_PERF_CNT_EN
  output logic [CNT_W-1:0]       perf_ctrl_cnt,
  output logic [CNT_W-1:0]       perf_mispred_cnt,
`endif
  branch_resolve_unit_if.slave   bus
);

  pred_slot_t      ifid_q, ifid_d;
  pred_slot_t      idex_q, idex_d;
  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;

  logic            bp_update_q, bp_update_d;
  logic [XLEN-1:0] bp_pc_q, bp_pc_d;
  logic [XLEN-1:0] bp_target_q, bp_target_d;
  logic            bp_taken_q, bp_taken_d;

  bru_compare #(
    .XLEN (XLEN)
  ) u_compare (
    .ex_valid_i    (idex_q.valid),
    .ex_pc_i       (idex_q.pc),
    .pred_pc_i     (idex_q.pred_pc),
    .ex_is_ctrl_i  (bus.ex_is_ctrl),
    .ex_taken_i    (bus.ex_taken),
    .ex_target_i   (bus.ex_target),
    .mispredict_o  (mispredict),
    .redirect_pc_o (redirect_pc)
  );

  always_comb begin
    ifid_d = ifid_q;
    idex_d = idex_q;
    if (mispredict) begin
      // Flush beats stall; the instruction fetched this cycle is dropped too.
      ifid_d.valid = 1'b0;
      idex_d.valid = 1'b0;
    end else if (bus.stall) begin
      idex_d = SLOT_BUBBLE;
    end else begin
      idex_d = ifid_q;
      ifid_d = '{valid:      bus.if_valid,
                 pc:         bus.if_pc,
                 pred_taken: bus.if_pred_taken,
                 pred_pc:    bus.if_pred_pc};
    end
  end

  // Both correct and mispredicted control instructions train; aliases do not.
  always_comb begin
    bp_update_d = idex_q.valid && bus.ex_is_ctrl;
    bp_pc_d     = idex_q.pc;
    bp_target_d = bus.ex_target;
    bp_taken_d  = bus.ex_taken;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_q      <= SLOT_BUBBLE;
      idex_q      <= SLOT_BUBBLE;
      bp_update_q <= 1'b0;
      bp_pc_q     <= '0;
      bp_target_q <= '0;
      bp_taken_q  <= 1'b0;
    end else begin
      ifid_q      <= ifid_d;
      idex_q      <= idex_d;
      bp_update_q <= bp_update_d;
      bp_pc_q     <= bp_pc_d;
      bp_target_q <= bp_target_d;
      bp_taken_q  <= bp_taken_d;
    end
  end

`ifdef BRU_PERF_CNT_EN
  logic [CNT_W-1:0] ctrl_cnt_q, ctrl_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  always_comb begin
    ctrl_cnt_d    = ctrl_cnt_q + CNT_W'(bp_update_q);
    mispred_cnt_d = mispred_cnt_q + CNT_W'(mispredict);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_cnt_q    <= '0;
      mispred_cnt_q <= '0;
    end else begin
      ctrl_cnt_q    <= ctrl_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign perf_ctrl_cnt    = ctrl_cnt_q;
  assign perf_mispred_cnt = mispred_cnt_q;
`endif

  assign bus.ex_valid    = idex_q.valid;
  assign bus.ex_pc       = idex_q.pc;
  assign bus.mispredict  = mispredict;
  assign bus.redirect_pc = redirect_pc;
  assign bus.bp_update   = bp_update_q;
  assign bus.bp_pc       = bp_pc_q;
  assign bus.bp_target   = bp_target_q;
  assign bus.bp_taken    = bp_taken_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural two-entry pipeline model.
module tb_branch_resolve_unit;

  logic clk = 1'b0;
  logic reset;
  int   n_total  = 0;
  int   n_passed = 0;
  logic chk_en   = 1'b0;

  always #5 clk = ~clk;

  branch_resolve_unit_if #(.XLEN(32)) bus_if ();

`ifdef BRU_PERF_CNT_EN
  logic [31:0] perf_ctrl_cnt, perf_mispred_cnt;
`endif

  branch_resolve_unit #(
    .XLEN  (32),
    .CNT_W (32)
  ) dut (
    .clk              (clk),
    .reset            (reset),
`ifdef BRU_PERF_CNT_EN
    .perf_ctrl_cnt    (perf_ctrl_cnt),
    .perf_mispred_cnt (perf_mispred_cnt),
`endif
    .bus              (bus_if)
  );

  // ---------------- behavioural model ----------------
  // Index 0 = instruction decoded next, index 1 = instruction in EX.
  logic        m_v [2];
  logic [31:0] m_pc[2];
  logic [31:0] m_pp[2];
  logic        e_bp_update;
  logic [31:0] e_bp_pc, e_bp_target;
  logic        e_bp_taken;
  logic [31:0] e_ctrl_cnt, e_mis_cnt;

  function automatic logic [31:0] m_actual();
    if (bus_if.ex_is_ctrl && bus_if.ex_taken) return bus_if.ex_target;
    return m_pc[1] + 32'd4;
  endfunction

  function automatic logic m_misp();
    return m_v[1] && (m_pp[1] != m_actual());
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_v[i]  <= 1'b0;
        m_pc[i] <= '0;
        m_pp[i] <= '0;
      end
      e_bp_update <= 1'b0;
      e_bp_pc     <= '0;
      e_bp_target <= '0;
      e_bp_taken  <= 1'b0;
      e_ctrl_cnt  <= '0;
      e_mis_cnt   <= '0;
    end else begin
      e_bp_update <= m_v[1] && bus_if.ex_is_ctrl;
      e_bp_pc     <= m_pc[1];
      e_bp_target <= bus_if.ex_target;
      e_bp_taken  <= bus_if.ex_taken;
      if (e_bp_update) e_ctrl_cnt <= e_ctrl_cnt + 1;
      if (m_misp())    e_mis_cnt  <= e_mis_cnt + 1;
      if (m_misp()) begin
        m_v[0] <= 1'b0;
        m_v[1] <= 1'b0;
      end else if (bus_if.stall) begin
        m_v[1]  <= 1'b0;
        m_pc[1] <= '0;
        m_pp[1] <= '0;
      end else begin
        m_v[1]  <= m_v[0];
        m_pc[1] <= m_pc[0];
        m_pp[1] <= m_pp[0];
        m_v[0]  <= bus_if.if_valid;
        m_pc[0] <= bus_if.if_pc;
        m_pp[0] <= bus_if.if_pred_pc;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    else n_passed++;
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ex_valid",    32'(bus_if.ex_valid),   32'(m_v[1]));
      if (m_v[1]) chk("ex_pc", bus_if.ex_pc, m_pc[1]);
      chk("mispredict",  32'(bus_if.mispredict), 32'(m_misp()));
      chk("redirect_pc", bus_if.redirect_pc,     m_misp() ? m_actual() : 32'h0);
      chk("bp_update",   32'(bus_if.bp_update),  32'(e_bp_update));
      if (e_bp_update) begin
        chk("bp_pc",     bus_if.bp_pc,           e_bp_pc);
        chk("bp_target", bus_if.bp_target,       e_bp_target);
        chk("bp_taken",  32'(bus_if.bp_taken),   32'(e_bp_taken));
      end
`ifdef BRU_PERF_CNT_EN
      chk("perf_ctrl_cnt",    perf_ctrl_cnt,    e_ctrl_cnt);
      chk("perf_mispred_cnt", perf_mispred_cnt, e_mis_cnt);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] ppc,
                     input logic pt, input logic st, input logic c, input logic t,
                     input logic [31:0] tg);
    bus_if.if_valid      = v;
    bus_if.if_pc         = pc;
    bus_if.if_pred_pc    = ppc;
    bus_if.if_pred_taken = pt;
    bus_if.stall         = st;
    bus_if.ex_is_ctrl    = c;
    bus_if.ex_taken      = t;
    bus_if.ex_target     = tg;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    bus_if.if_valid = 1'b0; bus_if.if_pc = '0; bus_if.if_pred_pc = '0;
    bus_if.if_pred_taken = 1'b0; bus_if.stall = 1'b0;
    bus_if.ex_is_ctrl = 1'b0; bus_if.ex_taken = 1'b0; bus_if.ex_target = '0;
    adv();
    chk_en = 1'b1;
    adv();
    // Reset state
    @(negedge clk);
    chk("rst ex_valid",   32'(bus_if.ex_valid),   32'h0);
    chk("rst mispredict", 32'(bus_if.mispredict), 32'h0);
    chk("rst bp_update",  32'(bus_if.bp_update),  32'h0);
    chk("rst bp_pc",      bus_if.bp_pc,           32'h0);
    adv();
    reset = 1'b0;

    // Straight-line, not taken
    cyc(1, 32'h00, 32'h04, 0, 0, 0, 0, 0); adv();
    cyc(1, 32'h04, 32'h08, 0, 0, 0, 0, 0); adv();
    cyc(1, 32'h08, 32'h0C, 0, 0, 0, 0, 0);
    chk("seq ex_pc0", bus_if.ex_pc, 32'h00);
    chk("seq misp0",  32'(bus_if.mispredict), 32'h0);
    adv();
    idle(); chk("seq ex_pc4", bus_if.ex_pc, 32'h04); adv();
    idle(); chk("seq ex_pc8", bus_if.ex_pc, 32'h08);
    chk("seq bp_update", 32'(bus_if.bp_update), 32'h0);
    adv(); idle(); adv();

    // Missed taken branch
    cyc(1, 32'h10, 32'h14, 0, 0, 0, 0, 0); adv();
    idle(); adv();
    cyc(1, 32'h14, 32'h18, 0, 0, 1, 1, 32'h40);
    chk("miss misp",     32'(bus_if.mispredict), 32'h1);
    chk("miss redirect", bus_if.redirect_pc,     32'h40);
    adv();
    idle();
    chk("miss ex_valid",  32'(bus_if.ex_valid),  32'h0);
    chk("miss bp_update", 32'(bus_if.bp_update), 32'h1);
    chk("miss bp_pc",     bus_if.bp_pc,          32'h10);
    chk("miss bp_target", bus_if.bp_target,      32'h40);
    chk("miss bp_taken",  32'(bus_if.bp_taken),  32'h1);
    adv();
    idle(); chk("miss pulse", 32'(bus_if.bp_update), 32'h0); adv();

    // Correct taken prediction
    cyc(1, 32'h20, 32'h80, 1, 0, 0, 0, 0); adv();
    idle(); adv();
    cyc(0, 32'h0, 32'h0, 0, 0, 1, 1, 32'h80);
    chk("hit misp",     32'(bus_if.mispredict), 32'h0);
    chk("hit redirect", bus_if.redirect_pc,     32'h0);
    adv();
    idle();
    chk("hit bp_update", 32'(bus_if.bp_update), 32'h1);
    chk("hit bp_taken",  32'(bus_if.bp_taken),  32'h1);
    chk("hit bp_target", bus_if.bp_target,      32'h80);
    adv();

    // Stall
    cyc(1, 32'h30, 32'h34, 0, 0, 0, 0, 0); adv();
    cyc(1, 32'h34, 32'h38, 0, 1, 0, 0, 0); adv();
    cyc(1, 32'h34, 32'h38, 0, 0, 0, 0, 0);
    chk("stall bubble", 32'(bus_if.ex_valid), 32'h0);
    adv();
    idle();
    chk("stall ex_valid", 32'(bus_if.ex_valid), 32'h1);
    chk("stall ex_pc",    bus_if.ex_pc,         32'h30);
    adv();
    idle(); chk("stall ex_pc next", bus_if.ex_pc, 32'h34); adv();
    idle(); adv();

    // Flush vs stall
    cyc(1, 32'h50, 32'h54, 0, 0, 0, 0, 0); adv();
    cyc(1, 32'h54, 32'h58, 0, 0, 0, 0, 0); adv();
    cyc(1, 32'h58, 32'h5C, 0, 1, 1, 1, 32'h200);
    chk("flush misp",     32'(bus_if.mispredict), 32'h1);
    chk("flush redirect", bus_if.redirect_pc,     32'h200);
    adv();
    idle(); chk("flush ex_valid", 32'(bus_if.ex_valid), 32'h0); adv();
    idle(); chk("flush ifid dropped", 32'(bus_if.ex_valid), 32'h0); adv();

    // Alias and wrap
    cyc(1, 32'hFFFF_FFFC, 32'h100, 1, 0, 0, 0, 0); adv();
    idle(); adv();
    cyc(0, 32'h0, 32'h0, 0, 0, 0, 1, 32'h100);
    chk("alias misp",     32'(bus_if.mispredict), 32'h1);
    chk("alias redirect", bus_if.redirect_pc,     32'h0);
    adv();
    idle(); chk("alias no train", 32'(bus_if.bp_update), 32'h0); adv();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic        v, pt, st, c, t, rs;
      logic [31:0] pc, ppc, tg;
      v  = ($urandom_range(0, 3) != 0);
      pc = {$urandom_range(0, 63), 2'b00};
      if ($urandom_range(0, 7) == 0) pc = 32'hFFFF_FFFC;
      pt = $urandom_range(0, 1);
      ppc = pt ? {$urandom_range(0, 63), 2'b00} : pc + 32'd4;
      st = ($urandom_range(0, 4) == 0);
      c  = ($urandom_range(0, 2) == 0);
      t  = $urandom_range(0, 1);
      tg = ($urandom_range(0, 1) == 1) ? m_pp[1] : {$urandom_range(0, 63), 2'b00};
      rs = ($urandom_range(0, 59) == 0);
      reset = rs;
      cyc(v, pc, ppc, pt, st, c, t, tg);
      adv();
    end
    reset = 1'b0;
    idle(); adv();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
